cernbe_submap_bridge: RTL

- Parametrised CERN-BE bus (VME-style) bridge: one master port to N_SUB CERN-BE submaps.
- Decodes the address to a submap slot and pipelines writes in and reads out.
- Holds the write address on the shared submap address bus while a write is outstanding, and defers colliding reads.
- Generates a timeout error acknowledge when a submap does not answer.
- Sits between the top-level register decoder and several slave register banks.

---
 rtl/cernbe_submap_bridge.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/cernbe_submap_bridge.sv
// CERN-BE bus bridge: one master port fanned out to N_SUB register submaps.
// Writes are registered one cycle and hold the shared submap address bus
// until acknowledged; a read that collides with a write waits in R_PEND and
// replays from its latched address once the write has finished. Both paths
// carry a saturating timeout that turns a silent submap into an error ack.
module cernbe_submap_bridge #(
    parameter int N_SUB   = 4,
    parameter int ADDR_W  = 8,
    parameter int SUB_AW  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [ADDR_W-1:2]       VMEAddr,
    output logic [DATA_W-1:0]       VMERdData,
    input  logic [DATA_W-1:0]       VMEWrData,
    input  logic                    VMERdMem,
    input  logic                    VMEWrMem,
    output logic                    VMERdDone,
    output logic                    VMEWrDone,
    output logic                    VMERdError,
    output logic                    VMEWrError,
    output logic [SUB_AW-1:2]       sub_VMEAddr_o,
    output logic [DATA_W-1:0]       sub_VMEWrData_o,
    output logic [N_SUB-1:0]        sub_VMERdMem_o,
    output logic [N_SUB-1:0]        sub_VMEWrMem_o,
    input  logic [N_SUB*DATA_W-1:0] sub_VMERdData_i,
    input  logic [N_SUB-1:0]        sub_VMERdDone_i,
    input  logic [N_SUB-1:0]        sub_VMEWrDone_i
);

    localparam int SLOT_W = ADDR_W - SUB_AW;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic {W_IDLE, W_WAIT} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_PEND, R_WAIT} r_state_t;

    // One-hot slot select; an unmapped slot (zero-extended index >= N_SUB) gives all zeros.
    function automatic logic [N_SUB-1:0] slot_sel(input logic [SLOT_W-1:0] slot);
        logic [N_SUB-1:0] sel;
        sel = '0;
        for (int k = 0; k < N_SUB; k++)
            if (32'(slot) == 32'(k)) sel[k] = 1'b1;
        return sel;
    endfunction

    // Timeout counters stop at TIMEOUT instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic              wr_req_d0;
    logic [ADDR_W-1:2] wr_adr_d0;
    logic [DATA_W-1:0] wr_dat_d0;
    logic [ADDR_W-1:2] rd_adr_q;
    logic [CNT_W-1:0]  wr_cnt, rd_cnt;
    logic              wr_err_q, rd_done_q, rd_err_q;
    logic [N_SUB-1:0]  wr_sel, rd_sel_now, rd_sel_lat, wr_strobe, rd_strobe;
    logic              wr_busy, wr_hit, wr_timeout, wr_unmapped;
    logic              rd_hit, rd_timeout, rd_unmapped;
    logic [DATA_W-1:0] rd_mux;

    assign wr_sel     = slot_sel(wr_adr_d0[ADDR_W-1:SUB_AW]);
    assign rd_sel_now = slot_sel(VMEAddr[ADDR_W-1:SUB_AW]);
    assign rd_sel_lat = slot_sel(rd_adr_q[ADDR_W-1:SUB_AW]);
    assign wr_busy    = (w_state == W_WAIT) || wr_req_d0;
    assign wr_hit     = (w_state == W_WAIT) && |(sub_VMEWrDone_i & wr_sel);

    // Register the write request; address and data are captured only on a strobe so they stay put while it is outstanding.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_req_d0 <= 1'b0;
            wr_adr_d0 <= '0;
            wr_dat_d0 <= '0;
            rd_adr_q  <= '0;
        end else begin
            wr_req_d0 <= VMEWrMem;
            if (VMEWrMem) begin
                wr_adr_d0 <= VMEAddr;
                wr_dat_d0 <= VMEWrData;
            end
            if (VMERdMem && r_state == R_IDLE) rd_adr_q <= VMEAddr;
        end
    end

    // Write FSM next state: strobe in the cycle after the request, then wait for Done or timeout.
    always_comb begin
        w_next      = w_state;
        wr_strobe   = '0;
        wr_timeout  = 1'b0;
        wr_unmapped = 1'b0;
        case (w_state)
            W_IDLE: if (wr_req_d0) begin
                if (|wr_sel) begin
                    wr_strobe = wr_sel;
                    w_next    = W_WAIT;
                    if (wr_cnt == CNT_LAST) begin
                        wr_timeout = 1'b1;
                        w_next     = W_IDLE;
                    end
                end else begin
                    wr_unmapped = 1'b1;
                end
            end
            W_WAIT: begin
                if (wr_hit) begin
                    w_next = W_IDLE;
                end else if (wr_cnt == CNT_LAST) begin
                    wr_timeout = 1'b1;
                    w_next     = W_IDLE;
                end
            end
        endcase
    end

    // Write state, timeout counter and registered error acknowledge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            w_state  <= W_IDLE;
            wr_cnt   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            w_state  <= w_next;
            wr_err_q <= wr_timeout | wr_unmapped;
            if (wr_hit || wr_timeout)
                wr_cnt <= '0;
            else if (|wr_strobe || w_state == W_WAIT)
                wr_cnt <= sat_inc(wr_cnt);
            else
                wr_cnt <= '0;
        end
    end

    // Read FSM next state: issue at once when the bus is free, otherwise park in R_PEND until the write is done.
    always_comb begin
        r_next      = r_state;
        rd_strobe   = '0;
        rd_hit      = 1'b0;
        rd_timeout  = 1'b0;
        rd_unmapped = 1'b0;
        case (r_state)
            R_IDLE: if (VMERdMem) begin
                if (wr_busy || VMEWrMem) begin
                    r_next = R_PEND;
                end else if (|rd_sel_now) begin
                    rd_strobe = rd_sel_now;
                    r_next    = R_WAIT;
                end else begin
                    rd_unmapped = 1'b1;
                end
            end
            R_PEND: if (!wr_busy) begin
                if (|rd_sel_lat) begin
                    rd_strobe = rd_sel_lat;
                    r_next    = R_WAIT;
                end else begin
                    rd_unmapped = 1'b1;
                    r_next      = R_IDLE;
                end
            end
            R_WAIT: begin
                if (|(sub_VMERdDone_i & rd_sel_lat)) begin
                    rd_hit = 1'b1;
                    r_next = R_IDLE;
                end else if (rd_cnt == CNT_LAST) begin
                    rd_timeout = 1'b1;
                    r_next     = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
        if (|rd_strobe && rd_cnt == CNT_LAST) begin
            rd_timeout = 1'b1;
            r_next     = R_IDLE;
        end
    end

    // Select the addressed slot's read data.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_SUB; k++)
            if (rd_sel_lat[k]) rd_mux = sub_VMERdData_i[k*DATA_W +: DATA_W];
    end

    // Read state, timeout counter and the one-cycle read-out pipeline.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= R_IDLE;
            rd_cnt    <= '0;
            rd_done_q <= 1'b0;
            rd_err_q  <= 1'b0;
            VMERdData <= '0;
        end else begin
            r_state   <= r_next;
            rd_done_q <= rd_hit | rd_timeout | rd_unmapped;
            rd_err_q  <= rd_timeout | rd_unmapped;
            if (rd_hit)
                VMERdData <= rd_mux;
            else if (rd_timeout || rd_unmapped)
                VMERdData <= '1;
            if (rd_hit || rd_timeout)
                rd_cnt <= '0;
            else if (|rd_strobe || r_state == R_WAIT)
                rd_cnt <= sat_inc(rd_cnt);
            else
                rd_cnt <= '0;
        end
    end

    assign sub_VMEAddr_o   = wr_busy ? wr_adr_d0[SUB_AW-1:2]
                           : (r_state == R_PEND) ? rd_adr_q[SUB_AW-1:2]
                           : VMEAddr[SUB_AW-1:2];
    assign sub_VMEWrData_o = wr_dat_d0;
    assign sub_VMEWrMem_o  = wr_strobe;
    assign sub_VMERdMem_o  = rd_strobe;
    assign VMEWrDone       = wr_hit | wr_err_q;
    assign VMEWrError      = wr_err_q;
    assign VMERdDone       = rd_done_q;
    assign VMERdError      = rd_err_q;

endmodule
